// File: rtl/simd_mem_sequencer_pkg.sv
// Shared types and helpers for the SIMD load/store sequencer.
// Optional coalescing of same-word loads is enabled by defining SIMD_MEM_COALESCE_EN.
package simd_mem_pkg;

  localparam int unsigned MAX_CORES  = 32;
  localparam int unsigned LANE_IDX_W = $clog2(MAX_CORES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } state_e;

  // Lane-index width for a given lane count; never narrower than one bit.
  function automatic int unsigned lane_idx_w(input int unsigned cores);
    return (cores > 1) ? $clog2(cores) : 1;
  endfunction

endpackage

// File: rtl/simd_mem_sequencer_if.sv
// Single-port data-memory bus between the sequencer (master) and datamemory (slave).
interface simd_mem_sequencer_if #(
  parameter int unsigned MEM_AW = 10,
  parameter int unsigned DW     = 32
);
  logic [MEM_AW-1:0] mem_addr;
  logic [DW-1:0]     mem_wdata;
  logic              mem_we;
  logic              mem_re;
  logic [DW-1:0]     mem_rdata;

  modport master (output mem_addr, mem_wdata, mem_we, mem_re, input mem_rdata);
  modport slave  (input mem_addr, mem_wdata, mem_we, mem_re, output mem_rdata);
endinterface

// File: rtl/simd_mem_sequencer_lane_pick.sv
// Find-first-set over the pending-lane mask: lowest-index pending lane wins.
module lane_pick #(
  parameter int unsigned CORES = 4,
  parameter int unsigned IW    = 2
) (
  input  logic [CORES-1:0] pending,
  output logic             valid,
  output logic [IW-1:0]    index
);

  always_comb begin
    valid = 1'b0;
    index = '0;
    for (int i = int'(CORES) - 1; i >= 0; i--) begin
      if (pending[i]) begin
        valid = 1'b1;
        index = IW'(i);
      end
    end
  end

endmodule

// File: rtl/simd_mem_sequencer.sv
// Serialises one lockstep LW/SW across CORES lanes onto a single-port data memory.
// Define SIMD_MEM_COALESCE_EN to serve all same-word load lanes with one read.
module simd_mem_sequencer
  import simd_mem_pkg::*;
#(
  parameter int unsigned CORES  = 4,
  parameter int unsigned AW     = 32,
  parameter int unsigned DW     = 32,
  parameter int unsigned MEM_AW = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                issue,
  input  logic                is_store,
  input  logic [CORES-1:0]    lane_en,
  input  logic [CORES*AW-1:0] addr_flat,
  input  logic [CORES*DW-1:0] wdata_flat,
  output logic                stall,
  output logic                done,
  output logic [CORES*DW-1:0] rdata_flat,
  simd_mem_sequencer_if.master mem
);

  localparam int unsigned IW = lane_idx_w(CORES);

  state_e            state, state_d;
  logic              is_store_q;
  logic [CORES-1:0]  pending, pending_d;
  logic [CORES-1:0]  cap_mask, cap_d;
  logic [CORES-1:0]  hit;
  logic [MEM_AW-1:0] word_q  [CORES];
  logic [DW-1:0]     wdata_q [CORES];
  logic [DW-1:0]     rdata_q [CORES];
  logic              pick_valid;
  logic [IW-1:0]     pick_idx;
  logic              start;
  logic              unused_addr;

  assign start       = (state == IDLE) && issue && (|lane_en);
  assign unused_addr = ^addr_flat;

  lane_pick #(.CORES(CORES), .IW(IW)) u_lane_pick (
    .pending (pending),
    .valid   (pick_valid),
    .index   (pick_idx)
  );

  // Lanes retired this ACCESS cycle: the picked lane, plus same-word loads when coalescing.
  always_comb begin
    hit           = '0;
    hit[pick_idx] = pick_valid;
`ifdef SIMD_MEM_COALESCE_EN
    if (!is_store_q) begin
      for (int i = 0; i < int'(CORES); i++) begin
        if (pending[i] && (word_q[i] == word_q[pick_idx])) hit[i] = pick_valid;
      end
    end
`else
`endif
  end

  always_comb begin
    state_d   = state;
    pending_d = pending;
    cap_d     = '0;
    case (state)
      IDLE: begin
        if (start) begin
          state_d   = ACCESS;
          pending_d = lane_en;
        end
      end
      ACCESS: begin
        pending_d = pending & ~hit;
        cap_d     = is_store_q ? '0 : hit;
        if (pending_d == '0) state_d = is_store_q ? DONE : DRAIN;
      end
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      pending    <= '0;
      cap_mask   <= '0;
      is_store_q <= 1'b0;
      for (int i = 0; i < int'(CORES); i++) begin
        word_q[i]  <= '0;
        wdata_q[i] <= '0;
        rdata_q[i] <= '0;
      end
    end else begin
      state    <= state_d;
      pending  <= pending_d;
      cap_mask <= cap_d;
      if (start) begin
        is_store_q <= is_store;
        for (int i = 0; i < int'(CORES); i++) begin
          word_q[i]  <= addr_flat[i*AW+2 +: MEM_AW];
          wdata_q[i] <= wdata_flat[i*DW +: DW];
        end
      end
      // Synchronous-read data arrives one cycle after the strobe.
      for (int i = 0; i < int'(CORES); i++) begin
        if (cap_mask[i]) rdata_q[i] <= mem.mem_rdata;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < int'(CORES); i++) rdata_flat[i*DW +: DW] = rdata_q[i];
  end

  // Strobes are gated by reset so an aborted store writes nothing in the reset cycle.
  assign mem.mem_addr  = (state == ACCESS) ? word_q[pick_idx] : '0;
  assign mem.mem_wdata = ((state == ACCESS) && is_store_q) ? wdata_q[pick_idx] : '0;
  assign mem.mem_we    = (state == ACCESS) && is_store_q && !reset;
  assign mem.mem_re    = (state == ACCESS) && !is_store_q && !reset;

  assign stall = ((state != IDLE) && (state != DONE)) || start;
  assign done  = (state == DONE);

endmodule

// File: tb/tb_simd_mem_sequencer.sv
// Directed self-checking bench for simd_mem_sequencer with a behavioural data memory.
module tb_simd_mem_sequencer;

  localparam int unsigned CORES  = 4;
  localparam int unsigned AW     = 32;
  localparam int unsigned DW     = 32;
  localparam int unsigned MEM_AW = 10;

  typedef struct packed {
    logic              we;
    logic [MEM_AW-1:0] addr;
    logic [DW-1:0]     wdata;
  } acc_t;

  logic                clk = 1'b0;
  logic                reset;
  logic                issue;
  logic                is_store;
  logic [CORES-1:0]    lane_en;
  logic [CORES*AW-1:0] addr_flat;
  logic [CORES*DW-1:0] wdata_flat;
  logic [CORES*DW-1:0] rdata_flat;
  logic                stall;
  logic                done;

  simd_mem_sequencer_if #(.MEM_AW(MEM_AW), .DW(DW)) mem_if ();

  simd_mem_sequencer #(.CORES(CORES), .AW(AW), .DW(DW), .MEM_AW(MEM_AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .issue      (issue),
    .is_store   (is_store),
    .lane_en    (lane_en),
    .addr_flat  (addr_flat),
    .wdata_flat (wdata_flat),
    .stall      (stall),
    .done       (done),
    .rdata_flat (rdata_flat),
    .mem        (mem_if)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem_arr [2**MEM_AW];

  always @(posedge clk) begin
    if (mem_if.mem_we) mem_arr[mem_if.mem_addr] <= mem_if.mem_wdata;
    if (mem_if.mem_re) mem_if.mem_rdata <= mem_arr[mem_if.mem_addr];
  end

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] model_mem [2**MEM_AW];
  logic [DW-1:0] exp_rd [CORES];
  acc_t          acc_q [$];
  logic [CORES*DW-1:0] rd_q [$];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one instruction, predict every strobe/latency from the model, then check cycle by cycle.
  task automatic run_op(input string tag, input logic st, input logic [3:0] en,
                        input logic [127:0] af, input logic [127:0] wf);
    int                n_acc;
    int                exp_done;
    logic [MEM_AW-1:0] seen [$];
    logic [MEM_AW-1:0] w;
    bit                dup;
    acc_t              a;
    acc_q.delete();
    for (int i = 0; i < 4; i++) begin
      if (en[i]) begin
        w   = af[i*32+2 +: MEM_AW];
        dup = 1'b0;
`ifdef SIMD_MEM_COALESCE_EN
        if (!st) begin
          foreach (seen[j]) if (seen[j] == w) dup = 1'b1;
        end
`endif
        if (!dup) begin
          seen.push_back(w);
          a.we    = st;
          a.addr  = w;
          a.wdata = wf[i*32 +: 32];
          acc_q.push_back(a);
        end
        if (st) model_mem[w] = wf[i*32 +: 32];
        else    exp_rd[i]    = model_mem[w];
      end
    end
    n_acc    = acc_q.size();
    exp_done = n_acc + (st ? 1 : 2);
    if (!st) rd_q.push_back({exp_rd[3], exp_rd[2], exp_rd[1], exp_rd[0]});

    @(negedge clk);
    issue = 1'b1; is_store = st; lane_en = en; addr_flat = af; wdata_flat = wf;
    #1 check({tag, "_stall_t0"}, stall, 1'b1);
    @(posedge clk);
    #1 issue = 1'b0; addr_flat = ~af; wdata_flat = ~wf;
    for (int c = 1; c <= exp_done; c++) begin
      @(negedge clk);
      check($sformatf("%s_done_t%0d", tag, c), done, (c == exp_done));
      check($sformatf("%s_stall_t%0d", tag, c), stall, (c != exp_done));
      if (c <= n_acc) begin
        a = acc_q.pop_front();
        check($sformatf("%s_we_t%0d", tag, c), mem_if.mem_we, a.we);
        check($sformatf("%s_re_t%0d", tag, c), mem_if.mem_re, !a.we);
        check($sformatf("%s_addr_t%0d", tag, c), mem_if.mem_addr, a.addr);
        if (a.we) check($sformatf("%s_wdata_t%0d", tag, c), mem_if.mem_wdata, a.wdata);
      end else begin
        check($sformatf("%s_we_t%0d", tag, c), mem_if.mem_we, 1'b0);
        check($sformatf("%s_re_t%0d", tag, c), mem_if.mem_re, 1'b0);
      end
      if (c == exp_done && !st) check({tag, "_rdata"}, rdata_flat, rd_q.pop_front());
    end
    @(negedge clk);
    check({tag, "_done_after"}, done, 1'b0);
    check({tag, "_stall_after"}, stall, 1'b0);
  endtask

  initial begin
    reset = 1'b1; issue = 1'b0; is_store = 1'b0; lane_en = '0;
    addr_flat = '0; wdata_flat = '0;
    for (int i = 0; i < 4; i++) exp_rd[i] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_stall", stall, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_we", mem_if.mem_we, 1'b0);
    check("rst_re", mem_if.mem_re, 1'b0);
    check("rst_addr", mem_if.mem_addr, '0);
    check("rst_wdata", mem_if.mem_wdata, '0);
    check("rst_rdata", rdata_flat, '0);
    reset = 1'b0;

    run_op("store4", 1'b1, 4'b1111, {32'd12, 32'd8, 32'd4, 32'd0}, {32'd0, 32'd1, 32'd2, 32'd3});
    for (int i = 0; i < 4; i++) check($sformatf("store4_mem%0d", i), mem_arr[i], 32'(3 - i));

    run_op("prep_load", 1'b1, 4'b1111, {32'd12, 32'd8, 32'd4, 32'd0}, {32'd103, 32'd102, 32'd101, 32'd100});
    run_op("load4", 1'b0, 4'b1111, {32'd12, 32'd8, 32'd4, 32'd0}, '0);
    run_op("sparse", 1'b0, 4'b0101, {32'd0, 32'd12, 32'd0, 32'd4}, '0);

    run_op("sameword", 1'b1, 4'b1111, {32'd16, 32'd16, 32'd16, 32'd16}, {32'd4, 32'd3, 32'd2, 32'd1});
    check("sameword_mem", mem_arr[4], 32'd4);

    @(negedge clk);
    issue = 1'b1; is_store = 1'b1; lane_en = 4'b0000;
    #1 check("nolane_stall_t0", stall, 1'b0);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      check($sformatf("nolane_stall_t%0d", c), stall, 1'b0);
      check($sformatf("nolane_done_t%0d", c), done, 1'b0);
      check($sformatf("nolane_we_t%0d", c), mem_if.mem_we, 1'b0);
      check($sformatf("nolane_re_t%0d", c), mem_if.mem_re, 1'b0);
    end
    issue = 1'b0;

    run_op("prep_rst", 1'b1, 4'b1111, {32'd92, 32'd88, 32'd84, 32'd80}, {32'd14, 32'd13, 32'd12, 32'd11});
    @(negedge clk);
    issue = 1'b1; is_store = 1'b1; lane_en = 4'b1111;
    addr_flat = {32'd92, 32'd88, 32'd84, 32'd80}; wdata_flat = {32'd24, 32'd23, 32'd22, 32'd21};
    @(posedge clk);
    #1 issue = 1'b0;
    @(negedge clk);
    check("rst_mid_we_t1", mem_if.mem_we, 1'b1);
    check("rst_mid_addr_t1", mem_if.mem_addr, 10'd20);
    @(negedge clk);
    reset = 1'b1;
    #1 check("rst_mid_we_t2", mem_if.mem_we, 1'b0);
    @(negedge clk);
    check("rst_mid_stall_t3", stall, 1'b0);
    check("rst_mid_we_t3", mem_if.mem_we, 1'b0);
    check("rst_mid_done_t3", done, 1'b0);
    check("rst_mid_rdata_t3", rdata_flat, '0);
    reset = 1'b0;
    check("rst_mid_mem20", mem_arr[20], 32'd21);
    check("rst_mid_mem21", mem_arr[21], 32'd12);
    model_mem[20] = 32'd21;
    for (int i = 0; i < 4; i++) exp_rd[i] = '0;
    run_op("post_rst_load", 1'b0, 4'b1111, {32'd92, 32'd88, 32'd84, 32'd80}, '0);

    run_op("prep_coal", 1'b1, 4'b0001, {32'd0, 32'd0, 32'd0, 32'd8}, {32'd0, 32'd0, 32'd0, 32'd7});
    run_op("coal_load", 1'b0, 4'b1111, {32'd8, 32'd8, 32'd8, 32'd8}, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
